// File: rtl/gate_mux_pkg.sv
// Shared definitions for the mux-gate sweep checker family: gate encodings,
// checker FSM states and the sweep length.
package gate_mux_pkg;

  localparam logic [2:0] GATE_NOT  = 3'd0;
  localparam logic [2:0] GATE_AND  = 3'd1;
  localparam logic [2:0] GATE_OR   = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XOR  = 3'd5;
  localparam logic [2:0] GATE_XNOR = 3'd6;
  localparam logic [2:0] GATE_RSVD = 3'd7;

  localparam int unsigned VEC_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Golden truth table for the two-input mux-built gates; combinational.
// The reserved encoding yields 0 and is never consulted by the checker.
module gate_ref_model
  import gate_mux_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      GATE_NOT:  y = ~a;
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_NAND: y = ~(a & b);
      GATE_NOR:  y = ~(a | b);
      GATE_XOR:  y = a ^ b;
      GATE_XNOR: y = ~(a ^ b);
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_mux_sweep_checker.sv
// Sweeps a two-input gate under test through all four input vectors, compares
// each settled output with the reference truth table and reports the result.
module gate_mux_sweep_checker
  import gate_mux_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic       bad_sel
);

  localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST = 2'(VEC_COUNT - 1);

  state_t           state;
  logic [2:0]       sel_q;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             y_exp;
  logic [3:0]       fail_next;

  gate_ref_model u_ref (
    .sel (sel_q),
    .a   (idx[1]),
    .b   (idx[0]),
    .y   (y_exp)
  );

  // Mask including the current vector, so pass can be settled on the last sample edge.
  always_comb begin
    fail_next = fail_vec;
    if (y_in != y_exp) begin
      fail_next[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      idx      <= '0;
      cnt      <= '0;
      pass     <= 1'b0;
      fail_vec <= '0;
      bad_sel  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= '0;
          cnt <= '0;
          if (start) begin
            if (gate_sel == GATE_RSVD) begin
              state    <= ST_DONE;
              bad_sel  <= 1'b1;
              fail_vec <= '1;
              pass     <= 1'b0;
            end else begin
              state    <= ST_DRIVE;
              sel_q    <= gate_sel;
              bad_sel  <= 1'b0;
              fail_vec <= '0;
              pass     <= 1'b0;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt == CNT_LAST) begin
            fail_vec <= fail_next;
            cnt      <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
              pass  <= (fail_next == 4'b0000) && !bad_sel;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          idx   <= '0;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state == ST_DRIVE);
  assign done  = (state == ST_DONE);
  assign a_out = busy & idx[1];
  assign b_out = busy & idx[0];

endmodule

// File: tb/tb_gate_mux_sweep_checker.sv
// Directed bench for gate_mux_sweep_checker with a behavioural gate under test
// whose fault mode is selectable per step.
module tb_gate_mux_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  logic       a_out, b_out, y_in;
  logic       busy, done, pass, bad_sel;
  logic [3:0] fail_vec;

  int         gut_func;   // gate the behavioural GUT implements
  int         gut_mode;   // 0 correct, 1 stuck at 0, 2 forced 1 at a=b=1
  int         checks = 0;
  int         errors = 0;

  gate_mux_sweep_checker #(.SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .gate_sel (gate_sel),
    .a_out    (a_out),
    .b_out    (b_out),
    .y_in     (y_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_vec (fail_vec),
    .bad_sel  (bad_sel)
  );

  always #5 clk = ~clk;

  function automatic logic truth(input int g, input logic a, input logic b);
    case (g)
      0:       return ~a;
      1:       return a & b;
      2:       return a | b;
      3:       return ~(a & b);
      4:       return ~(a | b);
      5:       return a ^ b;
      6:       return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    y_in = truth(gut_func, a_out, b_out);
    if (gut_mode == 1) y_in = 1'b0;
    if (gut_mode == 2 && a_out && b_out) y_in = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at edge E, wait for done (bounded), check latency and results,
  // then step into the idle cycle following done.
  task automatic run_sweep(input string tag, input logic [2:0] sel,
                           input logic [3:0] exp_fail, input logic exp_pass);
    int n;
    gate_sel = sel;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_e1"}, busy, 1);
    n = 1;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_fail_vec"}, fail_vec, exp_fail);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_bad_sel"}, bad_sel, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_pass_held"}, pass, exp_pass);
  endtask

  initial begin
    int         dones;
    logic [1:0] v;
    rst      = 1'b1;
    start    = 1'b0;
    gate_sel = 3'd0;
    gut_func = 1;
    gut_mode = 0;
    #12;
    chk("rst_outputs", {a_out, b_out, busy, done, pass, fail_vec, bad_sel}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // AND, correct: check vector sequence cycle by cycle
    gut_func = 1;
    gate_sel = 3'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 2'(i / 2);
      chk($sformatf("and_vec_c%0d", i), {busy, done, a_out, b_out}, {2'b10, v});
      tick();
    end
    chk("and_done_e9", {done, busy, pass, fail_vec}, {3'b101, 4'b0000});
    tick();
    chk("and_after_done", {done, busy, a_out, b_out, pass}, 5'b00001);

    // XOR with output stuck at 0
    gut_func = 5;
    gut_mode = 1;
    run_sweep("xor_stuck0", 3'd5, 4'b0110, 1'b0);

    // NOR wrong on vector 3, then immediate restart with a correct model
    gut_func = 4;
    gut_mode = 2;
    run_sweep("nor_bad_v3", 3'd4, 4'b1000, 1'b0);
    gut_mode = 0;
    run_sweep("nor_good", 3'd4, 4'b0000, 1'b1);

    // Reserved select
    gate_sel = 3'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("rsvd_e1", {done, bad_sel, fail_vec, pass, busy, a_out, b_out}, {2'b11, 4'b1111, 4'b0000});
    tick();
    chk("rsvd_after", {done, bad_sel, fail_vec, busy}, {2'b01, 4'b1111, 1'b0});

    // Reset during vector 2 aborts without done
    gut_func = 1;
    gate_sel = 3'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rst_mid_vec2", {busy, a_out, b_out}, 3'b110);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_async", {a_out, b_out, busy, done, pass, fail_vec, bad_sel}, 0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("rst_mid_no_done", dones, 0);
    run_sweep("after_rst", 3'd1, 4'b0000, 1'b1);

    // XNOR sweep with start re-pulse and gate_sel change mid-run
    gut_func = 6;
    gate_sel = 3'd6;
    start    = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    repeat (2) tick();
    gate_sel = 3'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        chk("xnor_ign_result", {pass, fail_vec}, 5'b10000);
      end
      tick();
    end
    chk("xnor_ign_one_done", dones, 1);
    chk("xnor_ign_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_mux_sweep_checker.md
# gate_mux_sweep_checker

Self-checking sweep stage that sits around one of the mux-built two-input logic gates. It drives the gate's `a`/`b` inputs through all four combinations, samples the gate's `y` after a fixed settle time, and compares each sample with the truth table of the selected gate type. It reports a per-vector fail mask and a pass flag. It replaces hand-written per-gate stimulus benches with one reusable hardware checker.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each input vector is held before `y_in` is sampled. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a sweep; honoured only in IDLE.
- `gate_sel`  in  3  gate type; captured when `start` is accepted. Encoding: 0 NOT, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
- `a_out`  out  1  drives the gate-under-test input `a`.
- `b_out`  out  1  drives the gate-under-test input `b`.
- `y_in`  in  1  gate-under-test output.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `pass`  out  1  1 when the last sweep had no mismatch; held until the next accepted `start`.
- `fail_vec`  out  4  bit i set when vector i mismatched; held like `pass`.
- `bad_sel`  out  1  1 when the last `start` carried `gate_sel`=7; held like `pass`.

## Operation
- States: IDLE, DRIVE, DONE.
- **IDLE**
  - `start`=1 with `gate_sel`≠7: capture `gate_sel`, clear `fail_vec`/`pass`/`bad_sel`, set vector index to 0 and settle counter to 0, go to DRIVE.
  - `start`=1 with `gate_sel`=7: go to DONE directly with `bad_sel`=1, `fail_vec`=4'hF, `pass`=0. No vectors are driven.
- **DRIVE**
  - Vector index i (2 bits) drives `a_out`=i[1] and `b_out`=i[0].
  - The settle counter counts 0..SETTLE_CYCLES-1. On the edge where it equals SETTLE_CYCLES-1, sample `y_in` and compare it against the expected value.
  - On mismatch, set `fail_vec[i]`.
  - Then: if i=3, go to DONE; otherwise increment i and reset the counter.
- **DONE**: `done`=1 for one cycle, `pass`=(`fail_vec`==0) && !`bad_sel`. Return to IDLE.
- Expected y per vector: NOT = ~a (`b` ignored, but all four vectors are still run); AND a&b; OR a|b; NAND ~(a&b); NOR ~(a|b); XOR a^b; XNOR ~(a^b).
- `start` during DRIVE or DONE is ignored and not queued.
- `gate_sel` changes after capture have no effect on the running sweep.
- In IDLE, `a_out`/`b_out` return to 0.

## Timing
- Reset values (asynchronous, all outputs): `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `fail_vec`=0, `bad_sel`=0. State IDLE, index 0, counter 0.
- Reset asserted mid-sweep aborts it immediately to the reset values. No `done` is produced.
- Let edge E be the edge where `start` is accepted.
  - `busy`=1 and vector 0 is on `a_out`/`b_out` from E+1.
  - Vector i is presented for exactly SETTLE_CYCLES cycles. `y_in` is sampled on the last edge of that window.
  - `busy` stays high for 4·SETTLE_CYCLES cycles.
  - `done` is high in the single cycle following the last sample; `busy` is 0 during that cycle.
  - Total start-to-`done` latency is 4·SETTLE_CYCLES+1 cycles.
- Bad select: `done` and `bad_sel` appear at E+1, and `busy` never rises.
- Back-to-back sweeps: the earliest accepted next `start` is in the cycle after `done`.
- The gate under test is combinational, so any SETTLE_CYCLES≥1 is sufficient.

## Structure
- Shared package `gate_mux_pkg` holds:
  - the `gate_sel` encoding constants (GATE_NOT..GATE_XNOR, GATE_RSVD=7);
  - the state enum;
  - the vector-count constant 4.
- Sub-module `gate_ref_model` (combinational) takes `sel`, `a`, `b` and produces the expected y. It is the golden truth table shared with future checkers.
- The counter width is derived from SETTLE_CYCLES (4 bits covers the legal range).

## Test plan
- AND gate correct, SETTLE_CYCLES=2, `gate_sel`=1, start at E → `a_out`/`b_out` sequence 00,01,10,11, each held 2 cycles; `done` at E+9; `pass`=1, `fail_vec`=0000.
- XOR model with `y_in` stuck at 0, `gate_sel`=5 → `fail_vec`=0110, `pass`=0.
- NOR model that is wrong only on vector 3 (y=1 at a=1,b=1) → `fail_vec`=1000, `pass`=0. Then immediately restart with a correct model → `pass`=1, `fail_vec`=0000.
- `gate_sel`=7 → `done` and `bad_sel`=1 at E+1, `fail_vec`=1111, `busy` stays 0, `a_out`/`b_out` stay 0.
- Reset asserted during vector 2 → all outputs at reset values asynchronously, no `done`; a new start runs a full clean sweep.
- `start` re-pulsed, and `gate_sel` changed from 6 to 1, during a running XNOR sweep → ignored; the sweep completes against XNOR with exactly one `done`.
